// File: rtl/spi_pkg.sv
// Shared SPI constants and edge helper. The SPI master uses the same constants in loopback tests.
package spi_pkg;

  localparam int         SPI_DATA_W     = 8;
  localparam logic [1:0] SPI_MODE0      = 2'b00;  // {CPOL, CPHA}
  localparam logic [7:0] SPI_DEFAULT_TX = 8'hFF;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  function automatic edge_t detect_edge(input logic cur, input logic prev);
    edge_t e;
    e.rise = cur & ~prev;
    e.fall = ~cur & prev;
    return e;
  endfunction

endpackage

// File: rtl/spi_slave_sync_ff.sv
// Generic N-flop synchroniser that brings one asynchronous pin into the clk domain.
module sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_r;

  // Shift the pin through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) chain_r <= {STAGES{RESET_VAL}};
    else       chain_r <= {chain_r[STAGES-2:0], d};
  end

  assign q = chain_r[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// Mode-0 SPI responder, MSB first, with UART-like rx/tx handshakes for the CPU.
module spi_slave
  import spi_pkg::*;
#(
  parameter int                DATA_W      = SPI_DATA_W,
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] DEFAULT_TX  = DATA_W'(SPI_DEFAULT_TX)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_SCK,
  input  logic              spi_MOSI,
  input  logic              spi_SS,
  output logic              spi_MISO,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_full,
  input  logic              rx_rd,
  output logic              rx_overrun
);

  localparam int              CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_W);
  localparam logic             CPOL     = SPI_MODE0[1];

  logic sck_sync_s, mosi_sync_s, ss_sync_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .reset(reset), .d(spi_SCK), .q(sck_sync_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(spi_MOSI), .q(mosi_sync_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
    .clk(clk), .reset(reset), .d(spi_SS), .q(ss_sync_s));

  logic              sck_hist_r, ss_hist_r, mosi_d_r;
  logic              sck_rise_r, sck_fall_r, ss_fall_r, ss_rise_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [DATA_W-2:0] rx_shift_r;
  logic [DATA_W-2:0] tx_shift_r;  // bits still to send; the current MSB sits in spi_MISO
  logic [DATA_W-1:0] tx_buf_r;

  edge_t             sck_edge_s, ss_edge_s;
  logic [DATA_W-1:0] rx_byte_s, tx_src_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              reload_s, shift_s, byte_done_s;

  assign sck_edge_s = detect_edge(sck_sync_s ^ CPOL, sck_hist_r);
  assign ss_edge_s  = detect_edge(ss_sync_s, ss_hist_r);
  assign rx_byte_s  = {rx_shift_r, mosi_d_r};
  assign tx_src_s   = tx_ready ? DEFAULT_TX : tx_buf_r;
  assign miso_oe    = ~ss_sync_s;

  // Bit-counter next state and the frame events derived from it.
  always_comb begin
    cnt_next_s  = bit_cnt_r;
    reload_s    = 1'b0;
    shift_s     = 1'b0;
    byte_done_s = 1'b0;
    if (ss_fall_r) begin
      cnt_next_s = '0;
      reload_s   = 1'b1;
    end else if (ss_rise_r) begin
      cnt_next_s = '0;
    end else if (sck_rise_r) begin
      cnt_next_s  = bit_cnt_r + CNT_ONE;
      byte_done_s = (bit_cnt_r == CNT_LAST);
    end else if (sck_fall_r && (bit_cnt_r == CNT_FULL)) begin
      cnt_next_s = '0;
      reload_s   = 1'b1;
    end else if (sck_fall_r && (bit_cnt_r != '0)) begin
      shift_s = 1'b1;
    end else begin
      cnt_next_s = bit_cnt_r;
    end
  end

  // Edge pulses, shift registers and the rx/tx handshake state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_hist_r <= CPOL;
      ss_hist_r  <= 1'b1;
      mosi_d_r   <= 1'b0;
      sck_rise_r <= 1'b0;
      sck_fall_r <= 1'b0;
      ss_fall_r  <= 1'b0;
      ss_rise_r  <= 1'b0;
      bit_cnt_r  <= '0;
      rx_shift_r <= '0;
      tx_shift_r <= '0;
      tx_buf_r   <= '0;
      spi_MISO   <= 1'b0;
      tx_ready   <= 1'b1;
      rx_data    <= '0;
      rx_full    <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      sck_hist_r <= sck_sync_s ^ CPOL;
      ss_hist_r  <= ss_sync_s;
      mosi_d_r   <= mosi_sync_s;
      // SCK activity only counts while selected.
      sck_rise_r <= sck_edge_s.rise & ~ss_sync_s;
      sck_fall_r <= sck_edge_s.fall & ~ss_sync_s;
      ss_fall_r  <= ss_edge_s.fall;
      ss_rise_r  <= ss_edge_s.rise;
      bit_cnt_r  <= cnt_next_s;

      if (sck_rise_r) rx_shift_r <= rx_byte_s[DATA_W-2:0];

      if (reload_s) begin
        tx_shift_r <= tx_src_s[DATA_W-2:0];
        spi_MISO   <= tx_src_s[DATA_W-1];
        tx_ready   <= 1'b1;
      end else if (shift_s) begin
        spi_MISO   <= tx_shift_r[DATA_W-2];
        tx_shift_r <= {tx_shift_r[DATA_W-3:0], 1'b0};
      end

      // A load in the reload cycle sees the pre-reload tx_ready and stays pending.
      if (tx_load && tx_ready) begin
        tx_buf_r <= tx_data;
        tx_ready <= 1'b0;
      end

      if (rx_rd) begin
        rx_full    <= 1'b0;
        rx_overrun <= 1'b0;
      end
      if (byte_done_s) begin
        if (!rx_full || rx_rd) begin
          rx_data <= rx_byte_s;
          rx_full <= 1'b1;
        end else begin
          rx_overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised self-checking bench for spi_slave with a byte-level reference model.
module tb_spi_slave;

  localparam logic [7:0] IDLE_TX = 8'hFF;

  logic       clk = 1'b0;
  logic       reset, spi_SCK, spi_MOSI, spi_SS, spi_MISO, miso_oe;
  logic       tx_load, tx_ready, rx_full, rx_rd, rx_overrun;
  logic [7:0] tx_data, rx_data;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: one optional pending tx byte, one rx holding register.
  logic       m_pend, m_rx_full, m_ovr;
  logic [7:0] m_buf, m_rx_data;
  logic [7:0] fr_mosi [0:3];

  always #5 clk = ~clk;

  spi_slave dut (
    .clk(clk), .reset(reset), .spi_SCK(spi_SCK), .spi_MOSI(spi_MOSI), .spi_SS(spi_SS),
    .spi_MISO(spi_MISO), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_full(rx_full), .rx_rd(rx_rd),
    .rx_overrun(rx_overrun));

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pend = 1'b0; m_buf = 8'h00; m_rx_data = 8'h00; m_rx_full = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic take_tx(output logic [7:0] v);
    v = m_pend ? m_buf : IDLE_TX;
    m_pend = 1'b0;
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clk); tx_data = v; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
    if (!m_pend) begin m_pend = 1'b1; m_buf = v; end
  endtask

  task automatic read_rx();
    @(negedge clk); rx_rd = 1'b1;
    @(negedge clk); rx_rd = 1'b0;
    m_rx_full = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_rx_data"}, rx_data, m_rx_data);
    check_eq({tag, "_rx_full"}, 8'(rx_full), 8'(m_rx_full));
    check_eq({tag, "_overrun"}, 8'(rx_overrun), 8'(m_ovr));
    check_eq({tag, "_tx_ready"}, 8'(tx_ready), 8'(!m_pend));
  endtask

  // Mode 0 at clk/8: MOSI changes with SCK low, MISO is sampled on the rising edge.
  task automatic xfer_byte(input logic [7:0] mo, input int nbits, input bit rd_last,
                           input bit lat_chk, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 7; i >= 8 - nbits; i--) begin
      spi_MOSI = mo[i];
      repeat (4) @(negedge clk);
      mi[i] = spi_MISO;
      spi_SCK = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        rx_rd = rd_last && (i == 0) && (k == 3);
        if (lat_chk && i == 0 && k == 3) check_eq("rx_full_early", 8'(rx_full), 8'd0);
        if (lat_chk && i == 0 && k == 4) check_eq("rx_full_latency", 8'(rx_full), 8'd1);
      end
      spi_SCK = 1'b0;
    end
  endtask

  task automatic frame(input int nbytes, input int rd_idx, input bit lat_chk, input string tag);
    logic [7:0] exp_mi, mi;
    spi_SS = 1'b0;
    take_tx(exp_mi);
    repeat (6) @(negedge clk);
    check_eq({tag, "_oe_on"}, 8'(miso_oe), 8'd1);
    check_eq({tag, "_tx_ready_start"}, 8'(tx_ready), 8'd1);
    for (int b = 0; b < nbytes; b++) begin
      xfer_byte(fr_mosi[b], 8, (b == rd_idx), lat_chk && (b == 0), mi);
      check_eq({tag, "_miso"}, mi, exp_mi);
      if (!m_rx_full || b == rd_idx) begin
        m_rx_data = fr_mosi[b]; m_rx_full = 1'b1;
        if (b == rd_idx) m_ovr = 1'b0;
      end else begin
        m_ovr = 1'b1;
      end
      take_tx(exp_mi);
    end
    repeat (4) @(negedge clk);
    spi_SS = 1'b1;
    repeat (6) @(negedge clk);
    check_eq({tag, "_oe_off"}, 8'(miso_oe), 8'd0);
    check_state(tag);
  endtask

  task automatic abort_frame(input logic [7:0] mo, input int nbits, input string tag);
    logic [7:0] unused_v, mi;
    spi_SS = 1'b0;
    take_tx(unused_v);
    repeat (6) @(negedge clk);
    xfer_byte(mo, nbits, 1'b0, 1'b0, mi);
    repeat (4) @(negedge clk);
    spi_SS = 1'b1;
    repeat (6) @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] mi;
    int n, rd_idx;
    reset = 1'b1; spi_SCK = 1'b0; spi_MOSI = 1'b0; spi_SS = 1'b1;
    tx_data = 8'h00; tx_load = 1'b0; rx_rd = 1'b0;
    m_reset();
    repeat (4) @(negedge clk);
    check_eq("rst_miso", 8'(spi_MISO), 8'd0);
    check_eq("rst_oe", 8'(miso_oe), 8'd0);
    check_state("rst");
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // Basic exchange with exact rx_full latency.
    load_tx(8'h3C);
    check_eq("tx_ready_after_load", 8'(tx_ready), 8'd0);
    fr_mosi[0] = 8'hA5;
    frame(1, -1, 1'b1, "a5");

    // Back-to-back bytes under one select; second byte overruns.
    read_rx();
    load_tx(8'h77);
    fr_mosi[0] = 8'h11; fr_mosi[1] = 8'h22;
    frame(2, -1, 1'b0, "b2b");

    // Abort after 5 bits, then a clean frame.
    read_rx();
    abort_frame(8'hF0, 5, "abort");
    fr_mosi[0] = 8'h0F;
    frame(1, -1, 1'b0, "post_abort");

    // rx_rd in the same clk as the second byte completes.
    read_rx();
    fr_mosi[0] = 8'h33; fr_mosi[1] = 8'h44;
    frame(2, 1, 1'b0, "rd_same");

    // Second load while a byte is pending is ignored.
    load_tx(8'hAA);
    load_tx(8'hBB);
    check_eq("dbl_load_ready", 8'(tx_ready), 8'd0);
    fr_mosi[0] = 8'h96;
    frame(1, -1, 1'b0, "dbl_load");

    // Reset in the middle of a frame.
    load_tx(8'hE3);
    spi_SS = 1'b0;
    repeat (6) @(negedge clk);
    load_tx(8'h12);
    xfer_byte(8'hC7, 3, 1'b0, 1'b0, mi);
    reset = 1'b1;
    spi_SS = 1'b1;
    @(negedge clk);
    m_reset();
    check_eq("midrst_miso", 8'(spi_MISO), 8'd0);
    check_eq("midrst_oe", 8'(miso_oe), 8'd0);
    check_state("midrst");
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    fr_mosi[0] = 8'h5A;
    frame(1, -1, 1'b0, "after_rst");

    // Randomised traffic.
    for (int it = 0; it < 30; it++) begin
      for (int l = $urandom_range(0, 2); l > 0; l--) load_tx(8'($urandom));
      if ($urandom_range(0, 1) == 1) read_rx();
      if ($urandom_range(0, 5) == 0) begin
        abort_frame(8'($urandom), $urandom_range(1, 7), "rnd_abort");
      end else begin
        n = $urandom_range(1, 3);
        for (int b = 0; b < n; b++) fr_mosi[b] = 8'($urandom);
        rd_idx = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n - 1) : -1;
        frame(n, rd_idx, 1'b0, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
